// File: rtl/uart_2480_pkg.sv
// Shared definitions for the uart_2480 receive/transmit pair: frame geometry,
// receiver state type and the baud divider helper.
package uart_2480_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                            input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchronizer for the asynchronous RX line, idling high out of reset,
// with falling-edge detect between the second and third stages.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rxd_sync,
    output logic fall
);

    logic rxd_d0;
    logic rxd_d1;
    logic rxd_d2;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rxd_d0 <= 1'b1;
            rxd_d1 <= 1'b1;
            rxd_d2 <= 1'b1;
        end else begin
            rxd_d0 <= uart_rxd;
            rxd_d1 <= rxd_d0;
            rxd_d2 <= rxd_d1;
        end
    end

    assign rxd_sync = rxd_d1;
    assign fall     = rxd_d2 & ~rxd_d1;

endmodule

// File: rtl/uart_recv_2480.sv
// UART receiver: 1 start, 8 data (LSB first), 1 stop, centre-sampled, returning
// the frame as {stop, data, start} with done / framing-error pulses.
module uart_recv_2480
    import uart_2480_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 49152000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               uart_rxd,
    output logic [FRAME_W-1:0] uart_dout,
    output logic               uart_done,
    output logic               frame_err,
    output logic               rx_busy
);

    localparam int unsigned BPS_CNT   = bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] HALF_LAST = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_W - 1);

    state_t              state;
    state_t              next_state;
    logic [15:0]         clk_cnt;
    logic [2:0]          bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic                rxd_sync;
    logic                fall;
    logic                start_hit;
    logic                bit_hit;
    logic                done_set;
    logic                err_set;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rxd_sync  (rxd_sync),
        .fall      (fall)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (fall) next_state = START;
            START:     if (clk_cnt == HALF_LAST) next_state = rxd_sync ? IDLE : DATA;
            DATA:      if (clk_cnt == BIT_LAST && bit_cnt == LAST_BIT) next_state = STOP;
            STOP:      if (clk_cnt == BIT_LAST) next_state = rxd_sync ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxd_sync) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        start_hit = (state == START) && (clk_cnt == HALF_LAST);
        bit_hit   = ((state == DATA) || (state == STOP)) && (clk_cnt == BIT_LAST);
        done_set  = (state == STOP) && bit_hit && rxd_sync;
        err_set   = (state == STOP) && bit_hit && !rxd_sync;
        rx_busy   = (state != IDLE);
    end

    // Pulses are registered so they appear the cycle after the stop-bit sample.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            uart_dout <= 10'h200;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= done_set;
            frame_err <= err_set;
            if (done_set) begin
                uart_dout <= {1'b1, shift, 1'b0};
            end
            case (state)
                START: begin
                    clk_cnt <= start_hit ? '0 : clk_cnt + 16'd1;
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_hit) begin
                        clk_cnt         <= '0;
                        shift[bit_cnt]  <= rxd_sync;
                        bit_cnt         <= bit_cnt + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    clk_cnt <= bit_hit ? '0 : clk_cnt + 16'd1;
                end
                default: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv_2480.sv
// Randomized scoreboard bench for uart_recv_2480: a line-level transmitter model
// queues expected pulses (cycle, kind, frame word); a monitor checks every cycle.
module tb_uart_recv_2480;

    localparam int unsigned B   = 16;
    localparam int unsigned H   = B / 2;
    // Line change after posedge n -> pulse visible in the cycle after posedge n+LAT
    localparam int unsigned LAT = 3 + H + 9 * B;

    typedef struct {
        bit          is_err;
        logic [9:0]  dout;
        int unsigned cyc;
    } exp_t;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic [9:0] uart_dout;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    int unsigned cyc         = 0;
    int unsigned checks      = 0;
    int unsigned errors      = 0;
    bit          rst_applied = 1'b0;
    logic [9:0]  exp_dout    = 10'h200;
    exp_t        q[$];
    exp_t        got;

    uart_recv_2480 #(.CLK_FREQ(160000), .UART_BPS(10000)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .uart_dout (uart_dout),
        .uart_done (uart_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc         <= cyc + 1;
        rst_applied <= !sys_rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (rst_applied) begin
            exp_dout = 10'h200;
            check("reset_dout", 32'(uart_dout), 32'h200);
            check("reset_done", 32'(uart_done), 0);
            check("reset_err",  32'(frame_err), 0);
            check("reset_busy", 32'(rx_busy),   0);
        end else begin
            if (uart_done || frame_err) begin
                check("pulse_exclusive", 32'(uart_done & frame_err), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse done=%0b err=%0b cycle=%0d required=no pulse",
                             uart_done, frame_err, cyc);
                end else begin
                    got = q.pop_front();
                    check("pulse_kind",  32'(frame_err), 32'(got.is_err));
                    check("pulse_cycle", cyc, got.cyc);
                    if (!got.is_err) exp_dout = got.dout;
                end
            end
            check("dout", 32'(uart_dout), 32'(exp_dout));
        end
    end

    task automatic tick_line(input logic v, input logic rst_n);
        @(posedge sys_clk);
        #1;
        uart_rxd  = v;
        sys_rst_n = rst_n;
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) tick_line(1'b1, 1'b1);
    endtask

    // rst_slot >= 0 pulses reset mid-way through that line slot and expects nothing
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int rst_slot);
        logic [9:0] w;
        exp_t       e;
        w = {stopb, d, 1'b0};
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < int'(B); c++) begin
                tick_line(w[s], !(s == rst_slot && c == 8));
                if (s == 0 && c == 0 && rst_slot < 0) begin
                    e.is_err = !stopb;
                    e.dout   = w;
                    e.cyc    = cyc + LAT;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic glitch();
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick_line(i >= 5, 1'b1);
            @(negedge sys_clk);
            if (rx_busy) cnt++;
        end
        check("glitch_busy_cycles", cnt, 8);
    endtask

    initial begin
        repeat (60000) @(posedge sys_clk);
        $display("FAIL watchdog cycle=%0d required=finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        logic        stopb;
        int unsigned hold;

        repeat (4) tick_line(1'b1, 1'b0);
        idle(5);

        send_frame(8'hA5, 1'b1, -1);
        idle(10);

        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(10);

        glitch();
        idle(10);

        send_frame(8'h3C, 1'b0, -1);
        repeat (40) tick_line(1'b0, 1'b1);
        @(negedge sys_clk);
        check("wait_idle_busy", 32'(rx_busy), 1);
        idle(10);
        send_frame(8'h11, 1'b1, -1);
        idle(10);

        d = 8'($urandom) | 8'hF0;
        send_frame(d, 1'b1, 5);
        idle(20);
        send_frame(8'h5A, 1'b1, -1);
        idle(10);

        for (int i = 0; i < 30; i++) begin
            d     = 8'($urandom);
            stopb = ($urandom_range(0, 5) != 0);
            send_frame(d, stopb, -1);
            if (!stopb) begin
                hold = $urandom_range(0, 30);
                repeat (hold) tick_line(1'b0, 1'b1);
                idle($urandom_range(3, 10));
            end else begin
                idle($urandom_range(0, 12));
            end
        end

        idle(200);
        check("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_recv_2480.md
Name: uart_recv_2480

Overview:
- UART receiver: the receive end of the 10-bit serial frame used by the board's UART transmit path (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Oversamples the asynchronous line with sys_clk, samples each bit at its centre and returns a 10-bit frame word laid out like the transmit-side uart_din: bit0 = start, bits[8:1] = data, bit9 = stop.
- Pulses uart_done on a good frame and frame_err on a bad stop bit.
- Sits between the RX pin and the register/command logic.

Parameters:
- CLK_FREQ, 49152000, sys_clk frequency in Hz.
- UART_BPS, 9600, baud rate.
- BPS_CNT (localparam), CLK_FREQ/UART_BPS, sys_clk cycles per bit (5120 at defaults). Must be at least 4 and at most 65535.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_n  input  1  synchronous active-low reset.
- uart_rxd  input  1  asynchronous serial line; idles high.
- uart_dout  output  10  last good frame; [0]=start (0), [8:1]=data, [9]=stop (1).
- uart_done  output  1  one-cycle pulse; uart_dout is valid from this cycle onward.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset, sampled on the sys_clk edge while sys_rst_n=0:
  - uart_dout=10'h200; uart_done=0; frame_err=0; rx_busy=0.
  - State=IDLE; counters=0; synchronizer flops=1.
  - Reset mid-frame aborts the frame with no pulses. After reset the receiver waits in IDLE for a new falling edge.
- Synchronizer and edge detect:
  - uart_rxd passes through flops rxd_d0→rxd_d1→rxd_d2.
  - fall = rxd_d2 & ~rxd_d1.
  - Only rxd_d1 is used for sampling.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. clk_cnt is 16 bits; bit_cnt is 3 bits.
- IDLE:
  - On fall, go to START with clk_cnt=0.
  - fall is ignored in every other state.
- START:
  - clk_cnt increments each cycle.
  - At clk_cnt==BPS_CNT/2-1, sample rxd_d1.
  - If 1: false start, go to IDLE with no pulse.
  - If 0: go to DATA with clk_cnt=0 and bit_cnt=0.
- DATA:
  - At clk_cnt==BPS_CNT-1, sample rxd_d1 into shift[bit_cnt] (LSB first) and reset clk_cnt=0.
  - After bit_cnt==7 is sampled, go to STOP; otherwise bit_cnt increments.
- STOP:
  - At clk_cnt==BPS_CNT-1, sample rxd_d1.
  - If 1: next cycle uart_dout={1'b1, shift, 1'b0}, uart_done=1 for one cycle, go to IDLE. The receiver can accept a following start edge immediately, so back-to-back frames with one stop bit are supported.
  - If 0: frame_err=1 for one cycle, uart_dout unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_d1==1, then go to IDLE. This covers a break condition.
- Timing, with E = the cycle fall is first seen:
  - Start sample at E+BPS_CNT/2.
  - Data bit i sampled at E+BPS_CNT/2+(i+1)*BPS_CNT.
  - Stop sampled at E+BPS_CNT/2+9*BPS_CNT.
  - uart_done or frame_err asserted at stop sample +1 cycle.
- uart_done and frame_err are never high in the same cycle.
- uart_dout changes only in the uart_done cycle.

Decomposition:
- Package uart_2480_pkg:
  - FRAME_W=10 and DATA_W=8.
  - Enumerated state type (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Function bps_cnt(clk_freq, bps), shared with the transmitter.
- One sub-module, uart_rx_sync: 3-flop synchronizer with reset to 1. Outputs rxd_sync (rxd_d1) and fall.

Test Plan (CLK_FREQ=160000, UART_BPS=10000 → BPS_CNT=16; line driven by a bench model of the transmitter):
- Frame with data 8'hA5 → uart_done pulses at E+8+144+1 cycles; uart_dout=10'h34A; frame_err stays 0.
- Two back-to-back frames, 8'h00 then 8'hFF, with no idle gap → two uart_done pulses 160 cycles apart; uart_dout=10'h200, then 10'h3FE.
- Glitch: line low for 5 cycles only → returns to IDLE at E+8; no uart_done or frame_err; rx_busy high for 8 cycles.
- Data 8'h3C with stop bit low, line held low for 40 more cycles → frame_err pulse; uart_dout keeps its previous value; stays in WAIT_IDLE until the line is high; the next good frame 8'h11 gives uart_dout=10'h222.
- sys_rst_n=0 for one cycle during data bit 4 → all outputs return to reset values; no pulse for the aborted frame; the next full frame 8'h5A gives uart_dout=10'h2B4.
